// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared MD op encodings, FSM states and default latencies
// MDU_MADD_EN makes op 111 a multiply-accumulate instead of a no-op.
package mul_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110,
      MD_MADD  = 3'b111
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEFAULT = 5;
   localparam int DIV_CYCLES_DEFAULT  = 10;

   function automatic logic is_mult_op(input md_op_e op);
`ifdef MDU_MADD_EN
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD);
`else
      return (op == MD_MULT) || (op == MD_MULTU);
`endif
   endfunction

   function automatic logic is_div_op(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mul_div_unit_md_datapath.sv
// rtl/mul_div_unit_md_datapath.sv - combinational {hi,lo} result for the latched MD op
// MDU_MADD_EN adds the signed multiply-accumulate path.
module md_datapath
   import mul_div_unit_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] result
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_sdiv;
   logic [31:0] b_udiv;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_s;
   logic [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;

   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   assign a_mag  = a[31] ? -a : a;
   assign b_mag  = b[31] ? -b : b;
   assign b_sdiv = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign b_udiv = (b == 32'd0) ? 32'd1 : b;
   assign q_mag  = a_mag / b_sdiv;
   assign r_mag  = a_mag % b_sdiv;
   assign q_s    = (a[31] ^ b[31]) ? -q_mag : q_mag;
   assign r_s    = a[31] ? -r_mag : r_mag;
   assign q_u    = a / b_udiv;
   assign r_u    = a % b_udiv;

   always_comb begin
      result = {hi, lo};
      case (op)
         MD_MULT:  result = prod_s;
         MD_MULTU: result = prod_u;
         MD_DIV:   if (b != 32'd0) result = {r_s, q_s};
         MD_DIVU:  if (b != 32'd0) result = {r_u, q_u};
`ifdef MDU_MADD_EN
         MD_MADD:  result = {hi, lo} + prod_s;
`endif
         default:  result = {hi, lo};
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle mult/div unit owning HI/LO, with busy for hazard stalls
// MDU_MADD_EN enables op 111 (madd) with MULT_CYCLES latency.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdOp,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   md_state_e   state;
   md_state_e   state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   md_op_e      op_in;
   md_op_e      op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [63:0] result;
   logic        launch;
   logic        commit;
   logic        wr_hi;
   logic        wr_lo;

   assign op_in = md_op_e'(mdOp);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      launch     = 1'b0;
      commit     = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (is_mult_op(op_in)) begin
                  launch     = 1'b1;
                  cnt_next   = CW'(MULT_CYCLES);
                  state_next = S_RUN;
               end else if (is_div_op(op_in)) begin
                  launch     = 1'b1;
                  cnt_next   = CW'(DIV_CYCLES);
                  state_next = S_RUN;
               end else if (op_in == MD_MTHI) begin
                  wr_hi = 1'b1;
               end else if (op_in == MD_MTLO) begin
                  wr_lo = 1'b1;
               end
            end
         end
         S_RUN: begin
            // Any start seen here is dropped; the hazard unit never issues one.
            cnt_next = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               commit     = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= MD_NONE;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (launch) begin
            op_q <= op_in;
            a_q  <= dataA;
            b_q  <= dataB;
         end
         if (commit) {hi_q, lo_q} <= result;
         if (wr_hi) hi_q <= dataA;
         if (wr_lo) lo_q <= dataA;
      end
   end

   md_datapath u_datapath (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi     (hi_q),
      .lo     (lo_q),
      .result (result)
   );

   assign busy = (state == S_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage of the pipelined MIPS core.
- Owns the architectural HI/LO registers and executes mult/multu/div/divu/mthi/mtlo.
- Drives busy so the hazard unit stalls any later MD instruction or mfhi/mflo until the result is ready.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe for the op on mdOp, one cycle.
- mdOp  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 madd (see Optional Feature).
- dataA  input  32  rs operand, or dividend.
- dataB  input  32  rt operand, or divisor.
- busy  output  1  high while a mult/div is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: asynchronous, active-high. Forces hi=0, lo=0, busy=0, counter=0, FSM to IDLE. Takes effect at any time, including mid-operation, and the in-flight result is discarded.
- FSM states: IDLE, RUN.
- IDLE + start + mult/multu/div/divu:
  - Latch the operands and the op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Enter RUN; busy=1 from the next cycle.
- RUN: decrement counter each cycle. When counter==1, at that edge write hi/lo, clear busy and return to IDLE. busy is high for exactly N cycles and the new hi/lo are visible in the first cycle busy=0.
- IDLE + start + mthi/mtlo: hi (or lo) <= dataA at that edge, 1-cycle effect, busy stays 0.
- start while busy=1: ignored for every op, including mthi/mtlo; the hazard unit guarantees this never happens. Operand changes during RUN have no effect.
- mdOp=000, or start=0: no state change.
- mult: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
- multu: same, unsigned.
- div: signed, quotient truncated toward zero, remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned; lo = quotient, hi = remainder.
- Divide by zero (div or divu): hi/lo unchanged. busy still runs the full DIV_CYCLES.
- Product and quotient are computed combinationally from the latched operands; the latency is modelled by the counter only.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: mdOp=111 is madd, signed {hi,lo} <= {hi,lo} + dataA*dataB, modulo 2^64, latency MULT_CYCLES.
- Undefined: mdOp=111 is treated as none (no state change, busy stays 0).

Decomposition:
- Shared package holds:
  - mdOp encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD).
  - FSM state encodings.
  - Default latency constants.
  The decoder and hazard unit reuse these encodings.
- One natural sub-module: md_datapath. It is combinational and produces the 64-bit {hi_next, lo_next} from the latched op, latched operands and the current hi/lo, with the divide-by-zero guard. mul_div_unit keeps the FSM, counter and registers.

Test Plan:
- mult dataA=0xFFFFFFFE (-2), dataB=3, start 1 cycle -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div -7/2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7/0 right after -> hi/lo unchanged, busy still 10 cycles.
- mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never rises. mtlo issued during busy -> ignored.
- Assert reset for 1 cycle, asynchronously and mid-cycle, at cycle 3 of a div -> busy, hi, lo drop to 0 immediately and no result is written later.
  - Next mult after reset completes normally.
- With MDU_MADD_EN: hi/lo=0/5, madd 2x3 -> lo=11, hi=0.
  - Without the macro: the same stimulus leaves hi/lo=0/5 and busy=0.
